// File: rtl/cla_pkg.sv
// Shared types and constants for the multi-precision CLA add/subtract sequencer.
package cla_pkg;

    localparam int BYTE_W = 8;

    localparam logic MODE_ADD = 1'b0;
    localparam logic MODE_SUB = 1'b1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } state_t;

endpackage

// File: rtl/cla8_core.sv
// Combinational 8-bit carry-lookahead adder; c6 is the carry into bit 7 for overflow detection.
module cla8_core
    import cla_pkg::*;
(
    input  logic [BYTE_W-1:0] a,
    input  logic [BYTE_W-1:0] b,
    input  logic              cin,
    output logic [BYTE_W-1:0] sum,
    output logic              cout,
    output logic              c6
);

    logic [BYTE_W-1:0] g;
    logic [BYTE_W-1:0] p;
    logic [BYTE_W:0]   gx;
    logic [BYTE_W:0]   c;

    assign g  = a & b;
    assign p  = a ^ b;
    assign gx = {g, cin};

    // Each carry is the flat OR of every generate term propagated up to it,
    // so no carry depends on a lower carry.
    always_comb begin
        logic t;
        logic cn;
        c    = '0;
        c[0] = cin;
        for (int i = 0; i < BYTE_W; i++) begin
            cn = 1'b0;
            for (int k = 0; k <= i + 1; k++) begin
                t = gx[k];
                for (int m = k; m <= i; m++) begin
                    t = t & p[m];
                end
                cn = cn | t;
            end
            c[i+1] = cn;
        end
    end

    assign sum  = p ^ c[BYTE_W-1:0];
    assign cout = c[BYTE_W];
    assign c6   = c[BYTE_W-1];

endmodule

// File: rtl/cla_mp_add_seq.sv
// Multi-precision add/subtract sequencer streaming LSB-first bytes through cla8_core.
// Optional ZERO_FLAG_EN adds a 'zero' result flag output.
module cla_mp_add_seq
    import cla_pkg::*;
#(
    parameter int NBYTES = 4,
    parameter int CW     = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              sub,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [BYTE_W-1:0] a_in,
    input  logic [BYTE_W-1:0] b_in,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [BYTE_W-1:0] sum_out,
    output logic              out_last,
    output logic              carry_out,
    output logic              overflow,
    output logic              busy,
`ifdef ZERO_FLAG_EN
    output logic              zero,
`endif
    output logic              done
);

    state_t            state;
    state_t            state_next;
    logic [CW-1:0]     beat_cnt;
    logic              carry_reg;
    logic              sub_reg;
    logic              accept;
    logic              out_fire;
    logic              last_beat;
    logic              start_ok;
    logic [BYTE_W-1:0] b_eff;
    logic [BYTE_W-1:0] sum_p0;
    logic              cout_p0;
    logic              c6_p0;

    assign in_ready  = (state == RUN) && (!out_valid || out_ready);
    assign accept    = in_valid && in_ready;
    assign out_fire  = out_valid && out_ready;
    assign last_beat = (beat_cnt == CW'(NBYTES - 1));
    assign start_ok  = (state == IDLE) && start;
    assign busy      = (state != IDLE);
    assign b_eff     = b_in ^ {BYTE_W{sub_reg}};

    cla8_core u_core (
        .a    (a_in),
        .b    (b_eff),
        .cin  (carry_reg),
        .sum  (sum_p0),
        .cout (cout_p0),
        .c6   (c6_p0)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (start) state_next = RUN;
            RUN:     if (accept && last_beat) state_next = DRAIN;
            DRAIN:   if (out_fire && out_last) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Stage p0 -> registered output byte; carry chains byte to byte via carry_reg.
    always_ff @(posedge clk) begin
        if (rst) begin
            beat_cnt  <= '0;
            carry_reg <= 1'b0;
            sub_reg   <= MODE_ADD;
            sum_out   <= '0;
            out_valid <= 1'b0;
            out_last  <= 1'b0;
            carry_out <= 1'b0;
            overflow  <= 1'b0;
            done      <= 1'b0;
        end else begin
            done <= out_fire && out_last;
            if (start_ok) begin
                sub_reg   <= sub;
                carry_reg <= (sub == MODE_SUB);
                beat_cnt  <= '0;
                carry_out <= 1'b0;
                overflow  <= 1'b0;
            end
            if (accept) begin
                sum_out   <= sum_p0;
                out_valid <= 1'b1;
                out_last  <= last_beat;
                carry_reg <= cout_p0;
                beat_cnt  <= beat_cnt + 1'b1;
                if (last_beat) begin
                    carry_out <= cout_p0;
                    overflow  <= c6_p0 ^ cout_p0;
                end
            end else if (out_fire) begin
                out_valid <= 1'b0;
                out_last  <= 1'b0;
            end
        end
    end

`ifdef ZERO_FLAG_EN
    logic nz_acc;

    // Sticky "some byte was non-zero"; the flag is resolved on the final beat.
    always_ff @(posedge clk) begin
        if (rst) begin
            nz_acc <= 1'b0;
            zero   <= 1'b0;
        end else begin
            if (start_ok) begin
                nz_acc <= 1'b0;
                zero   <= 1'b0;
            end
            if (accept) begin
                nz_acc <= nz_acc | (|sum_p0);
                if (last_beat) begin
                    zero <= !(nz_acc | (|sum_p0));
                end
            end
        end
    end
`endif

endmodule

// File: tb/tb_cla_mp_add_seq.sv
// Scoreboard bench for cla_mp_add_seq (NBYTES=4); covers add/sub, flags, backpressure and reset abort.
module tb_cla_mp_add_seq;

    localparam int NB = 4;
    localparam int W  = 8 * NB;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic       sub;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] a_in;
    logic [7:0] b_in;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] sum_out;
    logic       out_last;
    logic       carry_out;
    logic       overflow;
    logic       busy;
    logic       done;
`ifdef ZERO_FLAG_EN
    logic       zero;
`endif

    logic rnd_rdy  = 1'b0;
    logic rnd_bit  = 1'b1;
    logic rdy_force;

    assign out_ready = rnd_rdy ? rnd_bit : rdy_force;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [7:0] b;
        logic       last;
        logic       co;
        logic       ov;
        logic       z;
    } exp_t;

    exp_t sbq[$];
    bit   sb_en    = 1'b1;
    bit   done_exp = 1'b0;

    cla_mp_add_seq #(.NBYTES(NB), .CW(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .sub       (sub),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a_in      (a_in),
        .b_in      (b_in),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum_out   (sum_out),
        .out_last  (out_last),
        .carry_out (carry_out),
        .overflow  (overflow),
        .busy      (busy),
`ifdef ZERO_FLAG_EN
        .zero      (zero),
`endif
        .done      (done)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        #1;
        rnd_bit = 1'($urandom_range(0, 1));
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Scoreboard monitor: compares every accepted output byte and the done pulse timing.
    always @(negedge clk) begin
        exp_t e;
        chk("done", {31'b0, done}, {31'b0, done_exp});
        done_exp = out_valid && out_ready && out_last && !rst;
        if (sb_en && out_valid && out_ready && !rst) begin
            if (sbq.size() == 0) begin
                chk("sb_underflow", 32'd1, 32'd0);
            end else begin
                e = sbq.pop_front();
                chk("sum_byte", {24'b0, sum_out}, {24'b0, e.b});
                chk("out_last", {31'b0, out_last}, {31'b0, e.last});
                if (e.last) begin
                    chk("carry_out", {31'b0, carry_out}, {31'b0, e.co});
                    chk("overflow", {31'b0, overflow}, {31'b0, e.ov});
`ifdef ZERO_FLAG_EN
                    chk("zero", {31'b0, zero}, {31'b0, e.z});
`endif
                end
            end
        end
    end

    task automatic push_exp(input logic [W-1:0] a, input logic [W-1:0] b, input logic s);
        logic [W:0] r;
        logic       ov;
        exp_t       e;
        if (s) r = {1'b0, a} + {1'b0, ~b} + 1;
        else   r = {1'b0, a} + {1'b0, b};
        if (s) ov = (a[W-1] != b[W-1]) && (r[W-1] != a[W-1]);
        else   ov = (a[W-1] == b[W-1]) && (r[W-1] != a[W-1]);
        for (int i = 0; i < NB; i++) begin
            e.b    = r[8*i +: 8];
            e.last = (i == NB - 1);
            e.co   = r[W];
            e.ov   = ov;
            e.z    = (r[W-1:0] == '0);
            sbq.push_back(e);
        end
    endtask

    task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic s);
        bit acc;
        bit got;
        push_exp(a, b, s);
        @(posedge clk); #1;
        start    = 1'b1;
        sub      = s;
        in_valid = 1'b1;
        a_in     = a[7:0];
        b_in     = b[7:0];
        @(posedge clk); #1;
        start = 1'b0;
        for (int i = 0; i < NB; i++) begin
            a_in     = a[8*i +: 8];
            b_in     = b[8*i +: 8];
            in_valid = 1'b1;
            acc      = 1'b0;
            for (int t = 0; t < 200 && !acc; t++) begin
                @(negedge clk);
                acc = in_ready;
                @(posedge clk); #1;
            end
            if (!acc) chk("accept_timeout", 32'd0, 32'd1);
        end
        in_valid = 1'b0;
        got = 1'b0;
        for (int t = 0; t < 200 && !got; t++) begin
            @(negedge clk);
            got = done;
        end
        chk("done_seen", {31'b0, got}, 32'd1);
        chk("sb_empty", sbq.size(), 32'd0);
    endtask

    task automatic chk_reset_vals();
        chk("rst_in_ready", {31'b0, in_ready}, 32'd0);
        chk("rst_out_valid", {31'b0, out_valid}, 32'd0);
        chk("rst_sum_out", {24'b0, sum_out}, 32'd0);
        chk("rst_out_last", {31'b0, out_last}, 32'd0);
        chk("rst_carry_out", {31'b0, carry_out}, 32'd0);
        chk("rst_overflow", {31'b0, overflow}, 32'd0);
        chk("rst_busy", {31'b0, busy}, 32'd0);
        chk("rst_done", {31'b0, done}, 32'd0);
`ifdef ZERO_FLAG_EN
        chk("rst_zero", {31'b0, zero}, 32'd0);
`endif
    endtask

    initial begin
        logic [7:0] s0;
        bit         seen;
        rst       = 1'b1;
        start     = 1'b0;
        sub       = 1'b0;
        in_valid  = 1'b0;
        a_in      = '0;
        b_in      = '0;
        rdy_force = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk_reset_vals();

        run_op(32'h0000_00FF, 32'h0000_0001, 1'b0);
        run_op(32'hFFFF_FFFF, 32'h0000_0001, 1'b0);
        run_op(32'h7FFF_FFFF, 32'h0000_0001, 1'b0);
        run_op(32'h0000_0005, 32'h0000_0007, 1'b1);
        run_op(32'h8000_0000, 32'h0000_0001, 1'b1);
        run_op(32'h1234_5678, 32'h1234_5678, 1'b1);

        rnd_rdy = 1'b1;
        for (int k = 0; k < 6; k++) begin
            run_op($urandom, $urandom, 1'($urandom_range(0, 1)));
        end
        rnd_rdy = 1'b0;
        @(posedge clk); #2;

        // Backpressure: hold the first byte for several cycles, then release.
        rdy_force = 1'b0;
        fork
            run_op(32'h0403_0201, 32'h1020_3040, 1'b0);
            begin
                seen = 1'b0;
                for (int t = 0; t < 50 && !seen; t++) begin
                    @(negedge clk);
                    seen = out_valid;
                end
                chk("bp_valid_seen", {31'b0, seen}, 32'd1);
                s0 = sum_out;
                repeat (3) begin
                    @(negedge clk);
                    chk("bp_in_ready", {31'b0, in_ready}, 32'd0);
                    chk("bp_out_valid", {31'b0, out_valid}, 32'd1);
                    chk("bp_sum_stable", {24'b0, sum_out}, {24'b0, s0});
                end
                @(posedge clk); #1;
                rdy_force = 1'b1;
            end
        join

        // Abort after two accepted beats.
        sb_en = 1'b0;
        @(posedge clk); #1;
        start    = 1'b1;
        sub      = 1'b0;
        in_valid = 1'b1;
        a_in     = 8'h11;
        b_in     = 8'h22;
        @(posedge clk); #1;
        start = 1'b0;
        @(negedge clk);
        chk("abort_ready0", {31'b0, in_ready}, 32'd1);
        @(posedge clk); #1;
        @(negedge clk);
        chk("abort_ready1", {31'b0, in_ready}, 32'd1);
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst      = 1'b0;
        in_valid = 1'b0;
        @(negedge clk);
        chk_reset_vals();
        repeat (3) @(negedge clk);
        chk("abort_no_done", {31'b0, done}, 32'd0);
        sbq.delete();
        sb_en = 1'b1;
        run_op(32'h0000_0001, 32'h0000_0001, 1'b0);

        repeat (2) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
